// File: rtl/sm4_stream_ctrl.sv
// Host-side stream controller for sm4_core: key-expansion sequencing, 32->128 bit
// block packing with credit-gated issue, and a block FIFO unpacked to a 32-bit stream.
module sm4_stream_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] cfg_key,
  input  logic         cfg_encdec,
  input  logic         cfg_start,
  input  logic         cfg_abort,
  output logic         busy,
  output logic         key_ready,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         en_sm4,
  output logic         encdec,
  output logic         en_key_exps,
  output logic [127:0] key,
  output logic         key_valid,
  input  logic         key_exps_done,
  output logic [127:0] bdi,
  output logic         bdi_valid,
  input  logic [127:0] bdo,
  input  logic         bdo_valid
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_KEY_REQ  = 3'd1,
    ST_KEY_WAIT = 3'd2,
    ST_RUN      = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  state_t         state_r, state_nx;
  logic           start_acc_s;
  logic           drain_exit_s;
  logic           run_drain_s;

  logic           busy_r, key_ready_r, en_key_r, encdec_r, encdec_pend_r;
  logic [127:0]   key_r, key_pend_r;

  logic [1:0]     pk_idx_r;
  logic [127:0]   pk_data_r;
  logic           pk_full_r;
  logic           s_acc_s;

  logic [CW-1:0]  inflight_r;
  logic [CW-1:0]  fifo_cnt_r;
  logic [CW:0]    credit_sum_s;
  logic           credit_ok_s;
  logic           issue_s;
  logic [127:0]   bdi_r;
  logic           bdi_valid_r;

  logic [127:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [1:0]     out_idx_r;
  logic           wr_s, rd_s, m_valid_s, m_hs_s;

  assign run_drain_s  = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign drain_exit_s = (state_r == ST_DRAIN) && (state_nx == ST_KEY_REQ);

  // Next-state logic; abort overrides everything, cfg_start only counts in IDLE/RUN
  always_comb begin
    state_nx    = state_r;
    start_acc_s = 1'b0;
    if (cfg_abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            state_nx    = ST_KEY_REQ;
            start_acc_s = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_KEY_REQ:  state_nx = ST_KEY_WAIT;
        ST_KEY_WAIT: begin
          if (key_exps_done) state_nx = ST_RUN;
          else               state_nx = ST_KEY_WAIT;
        end
        ST_RUN: begin
          if (cfg_start) begin
            state_nx    = ST_DRAIN;
            start_acc_s = 1'b1;
          end else begin
            state_nx = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if ((inflight_r == {CW{1'b0}}) && !pk_full_r) state_nx = ST_KEY_REQ;
          else                                          state_nx = ST_DRAIN;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx;
  end

  // Control outputs; a key loaded from RUN is held pending until in-flight blocks drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r        <= 1'b0;
      key_ready_r   <= 1'b0;
      en_key_r      <= 1'b0;
      encdec_r      <= 1'b0;
      encdec_pend_r <= 1'b0;
      key_r         <= 128'd0;
      key_pend_r    <= 128'd0;
    end else begin
      busy_r      <= (state_nx != ST_IDLE);
      key_ready_r <= (state_nx == ST_RUN);
      en_key_r    <= (state_nx == ST_KEY_REQ);
      if (start_acc_s) begin
        key_pend_r    <= cfg_key;
        encdec_pend_r <= cfg_encdec;
      end
      if (start_acc_s && (state_r == ST_IDLE)) begin
        key_r    <= cfg_key;
        encdec_r <= cfg_encdec;
      end else if (drain_exit_s) begin
        key_r    <= key_pend_r;
        encdec_r <= encdec_pend_r;
      end
    end
  end

  assign busy        = busy_r;
  assign en_sm4      = busy_r;
  assign key_ready   = key_ready_r;
  assign en_key_exps = en_key_r;
  assign key_valid   = en_key_r;
  assign key         = key_r;
  assign encdec      = encdec_r;

  // Credit rule: in-flight blocks plus stored blocks never exceed FIFO capacity
  assign credit_sum_s = {1'b0, inflight_r} + {1'b0, fifo_cnt_r};
  assign credit_ok_s  = credit_sum_s < (CW + 1)'(FIFO_DEPTH);
  assign s_ready      = (state_r == ST_RUN) && !pk_full_r;
  assign s_acc_s      = s_valid && s_ready && !cfg_abort;
  assign issue_s      = pk_full_r && credit_ok_s && run_drain_s && !cfg_abort;
  // A result with nothing in flight is stale and must not touch the FIFO
  assign wr_s         = bdo_valid && run_drain_s && (inflight_r != {CW{1'b0}}) && !cfg_abort;

  // Packer: first accepted word lands in bits [127:96]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk_idx_r  <= 2'd0;
      pk_data_r <= 128'd0;
      pk_full_r <= 1'b0;
    end else if (cfg_abort || drain_exit_s) begin
      pk_idx_r  <= 2'd0;
      pk_full_r <= 1'b0;
    end else if (s_acc_s) begin
      pk_data_r[{~pk_idx_r, 5'd0} +: 32] <= s_data;
      pk_idx_r                           <= pk_idx_r + 2'd1;
      pk_full_r                          <= (pk_idx_r == 2'd3);
    end else if (issue_s) begin
      pk_full_r <= 1'b0;
    end
  end

  // Block issue to the core and in-flight credit accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdi_r       <= 128'd0;
      bdi_valid_r <= 1'b0;
      inflight_r  <= {CW{1'b0}};
    end else if (cfg_abort) begin
      bdi_valid_r <= 1'b0;
      inflight_r  <= {CW{1'b0}};
    end else begin
      bdi_valid_r <= issue_s;
      if (issue_s) bdi_r <= pk_data_r;
      case ({issue_s, wr_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign bdi       = bdi_r;
  assign bdi_valid = bdi_valid_r;

  assign m_valid_s = (fifo_cnt_r != {CW{1'b0}});
  assign m_hs_s    = m_valid_s && m_ready;
  assign rd_s      = m_hs_s && (out_idx_r == 2'd3);

  // FIFO storage, no reset needed: contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (wr_s) fifo_mem_r[wr_ptr_r] <= bdo;
  end

  // FIFO pointers, occupancy and unpacker word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
      out_idx_r  <= 2'd0;
    end else if (cfg_abort) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
      out_idx_r  <= 2'd0;
    end else begin
      if (wr_s)   wr_ptr_r  <= wr_ptr_r + PW'(1);
      if (rd_s)   rd_ptr_r  <= rd_ptr_r + PW'(1);
      if (m_hs_s) out_idx_r <= out_idx_r + 2'd1;
      case ({wr_s, rd_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  assign m_valid = m_valid_s;
  assign m_data  = m_valid_s ? fifo_mem_r[rd_ptr_r][{~out_idx_r, 5'd0} +: 32] : 32'd0;

endmodule

// File: tb/tb_sm4_stream_ctrl.sv
// Self-checking bench for sm4_stream_ctrl with a behavioural sm4_core stand-in
// (fixed latency, known-answer vectors for the reference key, XOR transform otherwise).
module tb_sm4_stream_ctrl;

  localparam int DEPTH = 4;
  localparam int LAT   = 12;
  localparam logic [127:0] KREF = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CREF = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] KEY3 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] KONE = {128{1'b1}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] cfg_key;
  logic         cfg_encdec, cfg_start, cfg_abort;
  logic         busy, key_ready;
  logic [31:0]  s_data;
  logic         s_valid, s_ready;
  logic [31:0]  m_data;
  logic         m_valid, m_ready;
  logic         en_sm4, encdec, en_key_exps, key_valid, key_exps_done;
  logic [127:0] key, bdi, bdo;
  logic         bdi_valid, bdo_valid;

  sm4_stream_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_key(cfg_key), .cfg_encdec(cfg_encdec), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .busy(busy), .key_ready(key_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .en_sm4(en_sm4), .encdec(encdec), .en_key_exps(en_key_exps), .key(key),
    .key_valid(key_valid), .key_exps_done(key_exps_done),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdo(bdo), .bdo_valid(bdo_valid)
  );

  // Core stand-in: reference vectors for KREF, XOR-with-key transform otherwise
  function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k, input logic e);
    if (e && k == KREF && d == KREF) return CREF;
    if (!e && k == KREF && d == CREF) return KREF;
    return e ? (d ^ k) : (d ^ ~k);
  endfunction

  logic [127:0] core_key;
  logic         core_enc;
  logic [2:0]   kx_cnt;
  logic [127:0] pipe_d [LAT];
  logic         pipe_v [LAT];
  logic         inject = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key      <= 128'd0;
      core_enc      <= 1'b0;
      kx_cnt        <= 3'd0;
      key_exps_done <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      key_exps_done <= (kx_cnt == 3'd1);
      if (en_key_exps && key_valid) begin
        core_key <= key;
        core_enc <= encdec;
        kx_cnt   <= 3'd3;
      end else if (kx_cnt != 3'd0) begin
        kx_cnt <= kx_cnt - 3'd1;
      end
      pipe_v[0] <= bdi_valid;
      pipe_d[0] <= core_f(bdi, core_key, core_enc);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bdo_valid = pipe_v[LAT-1] | inject;
  assign bdo       = pipe_d[LAT-1];

  logic [31:0] rx_q [$];
  int n_issue = 0, n_bdo = 0, kreq_bdo = 0;
  int n_err = 0, n_checks = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) rx_q.push_back(m_data);
    if (bdi_valid)   n_issue <= n_issue + 1;
    if (bdo_valid)   n_bdo   <= n_bdo + 1;
    if (en_key_exps) kreq_bdo <= n_bdo;
  end

  typedef struct {
    logic [127:0] key;
    logic         enc;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_blk(input int b);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[127-32*w -: 32] = {8'(b), 8'h5A, 8'(w), 8'hC3};
    return r;
  endfunction

  function automatic logic [31:0] rx_word(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic send_word(input logic [31:0] w);
    bit ok = 1'b0;
    int n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (n < 300 && !ok) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (!ok) fail_now("s_handshake");
  endtask

  task automatic send_block(input logic [127:0] b);
    for (int w = 0; w < 4; w++) send_word(b[127-32*w -: 32]);
  endtask

  task automatic wait_words(input int n);
    int c = 0;
    while (rx_q.size() < n && c < 600) begin
      tick();
      c++;
    end
    if (rx_q.size() < n) fail_now("rx_words");
  endtask

  task automatic wait_key_ready();
    int n = 0;
    while (!key_ready && n < 200) begin
      tick();
      n++;
    end
    check("key_ready", 128'(key_ready), 128'd1);
  endtask

  task automatic start_cfg(input logic [127:0] k, input logic e);
    cfg_key    = k;
    cfg_encdec = e;
    cfg_start  = 1'b1;
    tick();
    cfg_start  = 1'b0;
    wait_key_ready();
  endtask

  task automatic cmp_blocks(input string tag, input int b0, input int nb, input logic [127:0] k, input logic e);
    logic [127:0] exp;
    for (int b = 0; b < nb; b++) begin
      exp = core_f(mk_blk(b0 + b), k, e);
      for (int w = 0; w < 4; w++)
        check($sformatf("%s_b%0d_w%0d", tag, b, w), 128'(rx_word(4*b + w)), 128'(exp[127-32*w -: 32]));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 128'({busy, key_ready, s_ready, m_valid, en_sm4, encdec,
                              en_key_exps, key_valid, bdi_valid}), 128'd0);
    check({tag, "_m_data"}, 128'(m_data), 128'd0);
    check({tag, "_key"}, key, 128'd0);
    check({tag, "_bdi"}, bdi, 128'd0);
  endtask

  task automatic apply_row(input int r);
    logic [127:0] exp;
    rx_q.delete();
    m_ready = 1'b1;
    start_cfg(vecs[r].key, vecs[r].enc);
    send_block(vecs[r].din);
    wait_words(4);
    exp = vecs[r].dout;
    for (int w = 0; w < 4; w++)
      check($sformatf("vec%0d_w%0d", r, w), 128'(rx_word(w)), 128'(exp[127-32*w -: 32]));
  endtask

  initial begin
    int base_i, base_b;
    vecs[0] = '{key: KREF, enc: 1'b1, din: KREF, dout: CREF};
    vecs[1] = '{key: KREF, enc: 1'b0, din: CREF, dout: KREF};
    vecs[2] = '{key: 128'd0, enc: 1'b1, din: 128'h00112233445566778899aabbccddeeff,
                dout: 128'h00112233445566778899aabbccddeeff};
    vecs[3] = '{key: KONE, enc: 1'b1, din: 128'h00112233445566778899aabbccddeeff,
                dout: 128'hffeeddccbbaa99887766554433221100};

    cfg_key = 128'd0; cfg_encdec = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    s_data = 32'd0; s_valid = 1'b0; m_ready = 1'b0;
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // T1/T2 and extra vectors, re-keying through DRAIN between rows
    for (int r = 0; r < 4; r++) apply_row(r);

    // T3: output stalled, credit limits issue to DEPTH blocks
    rx_q.delete();
    m_ready = 1'b0;
    start_cfg(KEY3, 1'b1);
    base_i = n_issue;
    for (int b = 0; b < 5; b++) send_block(mk_blk(b));
    tick(LAT + 20);
    check("t3_issues", 128'(n_issue - base_i), 128'd4);
    check("t3_s_ready", 128'(s_ready), 128'd0);
    check("t3_m_valid", 128'(m_valid), 128'd1);
    m_ready = 1'b1;
    for (int b = 5; b < 8; b++) send_block(mk_blk(b));
    wait_words(32);
    tick(LAT + 10);
    check("t3_count", 128'(rx_q.size()), 128'd32);
    cmp_blocks("t3", 0, 8, KEY3, 1'b1);

    // T4: re-key with two blocks in flight
    rx_q.delete();
    base_i = n_issue;
    base_b = n_bdo;
    send_block(mk_blk(10));
    send_block(mk_blk(11));
    tick(3);
    check("t4_issued", 128'(n_issue - base_i), 128'd2);
    check("t4_none_back", 128'(n_bdo - base_b), 128'd0);
    cfg_key = KONE; cfg_encdec = 1'b1; cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("t4_drain_flags", 128'({busy, key_ready, s_ready}), 128'(3'b100));
    wait_key_ready();
    check("t4_no_issue_in_drain", 128'(n_issue - base_i), 128'd2);
    check("t4_kreq_after_return", 128'(kreq_bdo - base_b), 128'd2);
    wait_words(8);
    cmp_blocks("t4_old", 10, 2, KEY3, 1'b1);
    rx_q.delete();
    send_block(mk_blk(12));
    wait_words(4);
    cmp_blocks("t4_new", 12, 1, KONE, 1'b1);

    // T5: asynchronous reset mid-RUN, off the clock edge
    send_word(32'h11112222);
    send_word(32'h33334444);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("t5_async");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    apply_row(0);

    // T6: abort with FIFO full and a partial block held
    rx_q.delete();
    m_ready = 1'b0;
    start_cfg(KREF, 1'b1);
    for (int b = 20; b < 24; b++) send_block(mk_blk(b));
    tick(LAT + 10);
    check("t6_full_m_valid", 128'(m_valid), 128'd1);
    for (int w = 0; w < 3; w++) send_word(32'hABCD0000 + 32'(w));
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("t6_abort_flags", 128'({busy, m_valid, s_ready}), 128'd0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick(2);
    check("t6_stale_m_valid", 128'(m_valid), 128'd0);
    check("t6_credit", 128'(dut.inflight_r), 128'd0);
    base_i = n_issue;
    start_cfg(KREF, 1'b1);
    for (int b = 30; b < 34; b++) send_block(mk_blk(b));
    tick(LAT + 10);
    check("t6_reissue", 128'(n_issue - base_i), 128'd4);
    m_ready = 1'b1;
    wait_words(16);
    cmp_blocks("t6", 30, 4, KREF, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
